spi_xfer_sequencer: RTL
=======================

Name: spi_xfer_sequencer

Overview:
- Sequences the SPI master shared by two on-chip requesters: req0 (sensor configuration loader) and req1 (status/monitor readback).
- Arbitrates round-robin and issues one SPI write word per transaction, optionally followed by one SPI read word.
- Handles the SPI master's valid/busy and read-request/valid handshakes, with timeout, and returns a single tagged response.

Parameters:
- DATA_WIDTH, 32, SPI word width in bits.
- VALID_CYC, 2, cycles spi_sdo_valid_o is held high per write (≥1).
- GAP_CYC, 2, idle cycles between write completion and read request (≥0).
- TIMEOUT, 1023, maximum cycles in any wait state before abort (≥1).

Ports:
- clk_i  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- req0_valid_i  in  1  req0 transaction request; held until req0_ready_o
- req0_wdata_i  in  DATA_WIDTH  req0 write word
- req0_rd_i  in  1  1 = write then read back; 0 = write only
- req0_ready_o  out  1  one-cycle accept pulse for req0
- req1_valid_i  in  1  as req0
- req1_wdata_i  in  DATA_WIDTH  as req0
- req1_rd_i  in  1  as req0
- req1_ready_o  out  1  as req0
- rsp_valid_o  out  1  one-cycle response pulse
- rsp_id_o  out  1  requester index of the response
- rsp_rdata_o  out  DATA_WIDTH  read word (0 if write-only or error)
- rsp_err_o  out  1  timeout abort flag
- busy_o  out  1  high in every state except IDLE
- spi_sdo_data_o  out  DATA_WIDTH  word presented to the SPI master
- spi_sdo_valid_o  out  1  write request to the SPI master
- spi_sdo_busy_i  in  1  SPI master shifting a write word
- spi_sdi_req_o  out  1  read request to the SPI master
- spi_sdi_data_i  in  DATA_WIDTH  read word from the SPI master
- spi_sdi_valid_i  in  1  read word valid, one-cycle pulse

Behaviour:
- Reset (async, rst_n=0):
  - All outputs 0.
  - State IDLE.
  - Timeout and gap counters 0.
  - Round-robin pointer last_gnt=1, so req0 wins the first tie.
  - A reset mid-transaction aborts immediately; no response is issued.
- All outputs are registered. spi_sdo_data_o is loaded at accept and held until the next accept.
- States: IDLE, WR_REQ, WR_START, WR_END, GAP, RD_REQ, RD_WAIT, RESP.
- IDLE:
  - If any reqN_valid_i is high, grant a requester.
  - Only one requester valid: grant it.
  - Both valid: grant the index != last_gnt.
  - On the grant cycle: pulse reqN_ready_o for 1 cycle; capture wdata, rd flag and id; update last_gnt; go to WR_REQ.
  - Accept-to-spi_sdo_valid_o latency is 1 cycle.
- WR_REQ:
  - spi_sdo_valid_o=1 for exactly VALID_CYC cycles, then deasserts.
  - Go to WR_START.
- WR_START: wait for spi_sdo_busy_i=1, then go to WR_END.
- WR_END:
  - Wait for spi_sdo_busy_i=0.
  - Then go to GAP if rd=1, else RESP.
  - If busy rises and falls within one cycle of the WR_START check, it is still seen via the level checks; the SPI busy pulse is always ≥DATA_WIDTH cycles.
- GAP: wait GAP_CYC cycles; GAP_CYC=0 passes straight to RD_REQ.
- RD_REQ: spi_sdi_req_o=1 for 1 cycle, then go to RD_WAIT.
- RD_WAIT: on spi_sdi_valid_i=1, capture spi_sdi_data_i into rsp_rdata_o and go to RESP.
- RESP:
  - rsp_valid_o=1 for 1 cycle, with rsp_id_o and rsp_err_o.
  - Then IDLE.
  - A new grant cannot occur earlier than the cycle after RESP.
- Timeout:
  - A counter clears on entry to WR_START, WR_END and RD_WAIT and increments each cycle spent there.
  - Reaching TIMEOUT: drop spi_sdo_valid_o and spi_sdi_req_o, set rsp_err_o=1 and rsp_rdata_o=0, go to RESP.
  - Counter width is clog2(TIMEOUT+1); no wrap.
- Unsolicited inputs: spi_sdi_valid_i outside RD_WAIT is ignored; spi_sdo_busy_i outside WR_START/WR_END is ignored.
- A requester that drops valid before ready is not served. Any request present during a transaction waits; nothing is queued beyond the held valid.

Test Plan:
- Write-only: req0_valid=1, wdata=0xA5A5_0001, rd=0; SPI model busy for 32 cycles.
  - Expect req0_ready pulse, spi_sdo_data=0xA5A5_0001, spi_sdo_valid high 2 cycles.
  - Expect rsp_valid with id=0, err=0, rdata=0 after busy falls.
- Write+read: req1, rd=1; model returns 0x1234_5678.
  - Expect spi_sdi_req 1-cycle pulse exactly 2 cycles after busy falls.
  - Expect rsp id=1, rdata=0x1234_5678, err=0.
- Contention: req0 and req1 both held valid from reset.
  - Expect grants in order 0,1,0,1 over four transactions, each with exactly one ready pulse.
- Timeout: model never asserts busy, TIMEOUT=15.
  - Expect rsp_valid with err=1, rdata=0, 16±1 cycles after WR_START entry; busy_o=0 the following cycle.
- Reset mid-read: assert rst_n=0 during RD_WAIT.
  - Expect all outputs 0 asynchronously and no rsp_valid.
  - After release with both requesters valid, expect req0 granted first.
- Stray pulse: spi_sdi_valid_i pulses while in IDLE, then a write-only transaction runs.
  - Expect no response from the stray pulse; the transaction's response has rdata=0.

Source files
------------

// File: rtl/spi_xfer_sequencer.sv
// Round-robin sequencer sharing one SPI master between two requesters: one write word per
// transaction, optionally followed by one read word, with a per-wait timeout and tagged response.
module spi_xfer_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int VALID_CYC  = 2,
    parameter int GAP_CYC    = 2,
    parameter int TIMEOUT    = 1023
) (
    input  logic                  clk_i,
    input  logic                  rst_n,
    input  logic                  req0_valid_i,
    input  logic [DATA_WIDTH-1:0] req0_wdata_i,
    input  logic                  req0_rd_i,
    output logic                  req0_ready_o,
    input  logic                  req1_valid_i,
    input  logic [DATA_WIDTH-1:0] req1_wdata_i,
    input  logic                  req1_rd_i,
    output logic                  req1_ready_o,
    output logic                  rsp_valid_o,
    output logic                  rsp_id_o,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic                  busy_o,
    output logic [DATA_WIDTH-1:0] spi_sdo_data_o,
    output logic                  spi_sdo_valid_o,
    input  logic                  spi_sdo_busy_i,
    output logic                  spi_sdi_req_o,
    input  logic [DATA_WIDTH-1:0] spi_sdi_data_i,
    input  logic                  spi_sdi_valid_i
);
    localparam int TMO_W    = $clog2(TIMEOUT + 1);
    localparam int VLD_W    = $clog2(VALID_CYC + 1);
    localparam int GAP_W    = (GAP_CYC > 2) ? $clog2(GAP_CYC - 1) : 1;
    localparam int GAP_LAST = (GAP_CYC >= 2) ? GAP_CYC - 2 : 0;

    typedef enum logic [2:0] {
        S_IDLE, S_WR_REQ, S_WR_START, S_WR_END, S_GAP, S_RD_REQ, S_RD_WAIT, S_RESP
    } state_t;

    state_t                r_state;
    logic                  r_last_gnt;
    logic                  r_rd;
    logic [TMO_W-1:0]      r_tmo;
    logic [VLD_W-1:0]      r_vcnt;
    logic [GAP_W-1:0]      r_gap;
    logic                  r_ready0;
    logic                  r_ready1;
    logic                  r_rsp_valid;
    logic                  r_rsp_id;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic                  r_rsp_err;
    logic                  r_busy;
    logic [DATA_WIDTH-1:0] r_sdo_data;
    logic                  r_sdo_valid;
    logic                  r_sdi_req;

    logic w_any;
    logic w_gnt1;
    logic w_tmo_hit;

    // req1 wins only when alone or when req0 was served last
    assign w_any     = req0_valid_i | req1_valid_i;
    assign w_gnt1    = req1_valid_i & (~req0_valid_i | ~r_last_gnt);
    assign w_tmo_hit = (r_tmo == TMO_W'(TIMEOUT));

    // Transaction FSM; every output is a register updated here.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_last_gnt  <= 1'b1;
            r_rd        <= 1'b0;
            r_tmo       <= '0;
            r_vcnt      <= '0;
            r_gap       <= '0;
            r_ready0    <= 1'b0;
            r_ready1    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_busy      <= 1'b0;
            r_sdo_data  <= '0;
            r_sdo_valid <= 1'b0;
            r_sdi_req   <= 1'b0;
        end else begin
            r_ready0    <= 1'b0;
            r_ready1    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_sdi_req   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_ready0    <= ~w_gnt1;
                        r_ready1    <= w_gnt1;
                        r_rsp_id    <= w_gnt1;
                        r_last_gnt  <= w_gnt1;
                        r_sdo_data  <= w_gnt1 ? req1_wdata_i : req0_wdata_i;
                        r_rd        <= w_gnt1 ? req1_rd_i : req0_rd_i;
                        r_rsp_err   <= 1'b0;
                        r_rsp_rdata <= '0;
                        r_vcnt      <= '0;
                        r_busy      <= 1'b1;
                        r_state     <= S_WR_REQ;
                    end
                end
                S_WR_REQ: begin
                    if (r_vcnt == VLD_W'(VALID_CYC)) begin
                        r_sdo_valid <= 1'b0;
                        r_tmo       <= '0;
                        r_state     <= S_WR_START;
                    end else begin
                        r_sdo_valid <= 1'b1;
                        r_vcnt      <= r_vcnt + VLD_W'(1);
                    end
                end
                S_WR_START: begin
                    if (spi_sdo_busy_i) begin
                        r_tmo   <= '0;
                        r_state <= S_WR_END;
                    end else if (w_tmo_hit) begin
                        r_sdo_valid <= 1'b0;
                        r_rsp_err   <= 1'b1;
                        r_rsp_rdata <= '0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end else begin
                        r_tmo <= r_tmo + TMO_W'(1);
                    end
                end
                S_WR_END: begin
                    if (!spi_sdo_busy_i) begin
                        if (!r_rd) begin
                            r_rsp_valid <= 1'b1;
                            r_state     <= S_RESP;
                        end else if (GAP_CYC < 2) begin
                            // one idle cycle is inherent in the registered request
                            r_sdi_req <= 1'b1;
                            r_state   <= S_RD_REQ;
                        end else begin
                            r_gap   <= '0;
                            r_state <= S_GAP;
                        end
                    end else if (w_tmo_hit) begin
                        r_rsp_err   <= 1'b1;
                        r_rsp_rdata <= '0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end else begin
                        r_tmo <= r_tmo + TMO_W'(1);
                    end
                end
                S_GAP: begin
                    if (r_gap == GAP_W'(GAP_LAST)) begin
                        r_sdi_req <= 1'b1;
                        r_state   <= S_RD_REQ;
                    end else begin
                        r_gap <= r_gap + GAP_W'(1);
                    end
                end
                S_RD_REQ: begin
                    r_tmo   <= '0;
                    r_state <= S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    if (spi_sdi_valid_i) begin
                        r_rsp_rdata <= spi_sdi_data_i;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end else if (w_tmo_hit) begin
                        r_rsp_err   <= 1'b1;
                        r_rsp_rdata <= '0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end else begin
                        r_tmo <= r_tmo + TMO_W'(1);
                    end
                end
                S_RESP: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy      <= 1'b0;
                    r_sdo_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign req0_ready_o    = r_ready0;
    assign req1_ready_o    = r_ready1;
    assign rsp_valid_o     = r_rsp_valid;
    assign rsp_id_o        = r_rsp_id;
    assign rsp_rdata_o     = r_rsp_rdata;
    assign rsp_err_o       = r_rsp_err;
    assign busy_o          = r_busy;
    assign spi_sdo_data_o  = r_sdo_data;
    assign spi_sdo_valid_o = r_sdo_valid;
    assign spi_sdi_req_o   = r_sdi_req;

endmodule
